cla_adder_seq: RTL and testbench
================================

Name: cla_adder_seq

Overview:
- Parametrised, multi-cycle carry-lookahead adder/subtractor for the CPU datapath.
- Generalises the 4-bit CLA slice in two ways: any WIDTH, and an add/sub mode.
- Evaluates one CHUNK-bit lookahead group per clock, chaining the group carry through a register.
- Uses a valid/ready handshake on both input and output; reports flags and word-level group propagate/generate (P$, G$).

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits per lookahead group processed per cycle; legal range 1..8.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- c_in  input  1  carry-in; used for add only.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- out  output  WIDTH  sum/difference.
- c_out  output  1  carry out of the MSB.
- ovf  output  1  signed overflow.
- zero  output  1  out == 0.
- P$  output  1  word group propagate.
- G$  output  1  word group generate.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE.
  - All outputs go to 0 except in_ready, which goes to 1.
  - Internal operand, carry and accumulator registers clear.
  - Reset overrides any in-flight operation or held result; the aborted result is never presented.
- Effective operand: B' = sub ? ~in2 : in2. Carry-in: C0 = sub ? 1 : c_in. Both are latched at accept.
- Per-bit signals: p = a ^ b', g = a & b'.
- Per-chunk signals are standard 4-level lookahead:
  - Internal carries c[i+1] = g[i] | p[i]&c[i].
  - Chunk Pc = AND of the chunk's p bits.
  - Chunk Gc = lookahead generate of the chunk.
- Word accumulators, updated per chunk:
  - Pacc <= Pacc & Pc.
  - Gacc <= Gc | (Pc & Gacc).
  - Initialised to 1 and 0 at accept.
  - Final P$ = Pacc and G$ = Gacc; both are independent of C0.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. If in_valid, then on that edge latch in1, B', C0 and mode, set chunk index k=0, and go to RUN.
  - RUN: in_ready=0. On each edge, process chunk k (bits k*CHUNK .. k*CHUNK+CHUNK-1) using the registered carry; write the sum bits and register the chunk carry-out; k++. After chunk N-1 (N = WIDTH/CHUNK), go to DONE.
  - DONE: out_valid=1. out, c_out, ovf, zero, P$ and G$ are stable. On out_valid & out_ready go to IDLE.
- Latency: out_valid rises exactly N edges after the accept edge (N=4 at defaults).
- Throughput: one operation per N+2 cycles; there is no same-cycle accept when leaving DONE.
- Flags:
  - c_out = carry out of bit WIDTH-1. For subtract, c_out=1 means no borrow.
  - ovf = carry into bit WIDTH-1 XOR c_out.
  - zero = (out == 0).
- Backpressure: while out_ready=0 in DONE, all outputs hold indefinitely. in_valid is ignored outside IDLE; the operands are not captured.
- Wrap-around: out is the result mod 2^WIDTH; there is no saturation.
- Outputs are registered. Results are not cleared on leaving DONE; qualify them with out_valid only.

Decomposition:
- Shared package cpu_alu_pkg holds:
  - State encoding localparams IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Function clog2, for sizing the chunk counter.
- One sub-module is natural: cla_chunk, parametrised by CHUNK. It is a purely combinational lookahead group.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, Pc, Gc, and the carry into its MSB (needed for ovf on the last chunk).
  - It is instantiated once and reused each cycle via a chunk mux.

Test Plan (WIDTH=16, CHUNK=4):
1. Add 0xFFFF+0x0001, c_in=0 -> out_valid exactly 4 cycles after accept; out=0x0000, c_out=1, zero=1, ovf=0, P$=0, G$=1.
2. Sub 0x8000-0x0001 -> out=0x7FFF, c_out=1, ovf=1, zero=0. Sub 0x0003-0x0005 -> out=0xFFFE, c_out=0, ovf=0.
3. Add 0xFFFF+0x0000, c_in=1 -> out=0x0000, c_out=1, P$=1, G$=0. The carry ripples through all chunk registers.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, and an in_valid pulse meanwhile is not captured. With out_ready=1 -> in_ready=1 on the next cycle.
5. Reset mid-RUN: assert rst at chunk 2 of 0x1234+0x4321 -> next cycle in_ready=1, out_valid=0, out=0. A following 0x0001+0x0001 gives out=0x0002.
6. Back-to-back: 8 random add/sub pairs with out_ready tied high -> each result matches the reference model (mod 2^16, flags), with a spacing of N+2 cycles.

Source files
------------

// File: rtl/cpu_alu_pkg.sv
// Shared definitions for the CPU ALU datapath blocks: sequencer state encoding,
// result flag bundle and a constant-function clog2 for sizing counters.
package cpu_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic c_out;
        logic ovf;
        logic zero;
        logic p_word;
        logic g_word;
    } flags_t;

    // Ceiling log2; clog2(1) = 0, so callers clamp widths to at least 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cla_chunk.sv
// One CHUNK-bit carry-lookahead group: sum, carry out, group propagate/generate
// and the carry into the group MSB (used for signed overflow on the top chunk).
module cla_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             pc,
    output logic             gc,
    output logic             c_msb
);

    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] g;
    logic [CHUNK:0]   c;
    logic             gen;

    assign p = a ^ b;
    assign g = a & b;

    // Unrolled at elaboration into flat lookahead terms; gen is the carry
    // the group would produce with cin forced to 0.
    always_comb begin
        c    = '0;
        c[0] = cin;
        gen  = 1'b0;
        for (int i = 0; i < CHUNK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
            gen    = g[i] | (p[i] & gen);
        end
    end

    assign sum   = p ^ c[CHUNK-1:0];
    assign cout  = c[CHUNK];
    assign pc    = &p;
    assign gc    = gen;
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/cla_adder_seq.sv
// Multi-cycle carry-lookahead adder/subtractor: one CHUNK-bit group per clock,
// group carry chained through a register, valid/ready on both sides.
module cla_adder_seq
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             P$,
    output logic             G$
);

    localparam int N   = WIDTH / CHUNK;
    localparam int K_W = (clog2(N) > 0) ? clog2(N) : 1;
    localparam logic [K_W-1:0]   K_LAST     = K_W'(N - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    if ((CHUNK < 1) || (CHUNK > 8) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
        $error("cla_adder_seq: CHUNK must be 1..8 and divide WIDTH");
    end

    state_e           state_q,     state_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic             carry_q,     carry_d;
    logic [K_W-1:0]   k_q,         k_d;
    logic [WIDTH-1:0] sum_q,       sum_d;
    logic             pacc_q,      pacc_d;
    logic             gacc_q,      gacc_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q,       out_d;
    flags_t           flags_q,     flags_d;

    logic [31:0]      shamt;
    logic [CHUNK-1:0] ch_a;
    logic [CHUNK-1:0] ch_b;
    logic [CHUNK-1:0] ch_sum;
    logic             ch_cout;
    logic             ch_pc;
    logic             ch_gc;
    logic             ch_c_msb;

    // Chunk mux: select group k of the latched operands for the shared CLA slice.
    assign shamt = 32'(k_q) * 32'(CHUNK);
    assign ch_a  = CHUNK'(a_q >> shamt);
    assign ch_b  = CHUNK'(b_q >> shamt);

    cla_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (ch_a),
        .b     (ch_b),
        .cin   (carry_q),
        .sum   (ch_sum),
        .cout  (ch_cout),
        .pc    (ch_pc),
        .gc    (ch_gc),
        .c_msb (ch_c_msb)
    );

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        k_d         = k_q;
        sum_d       = sum_q;
        pacc_d      = pacc_q;
        gacc_d      = gacc_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        flags_d     = flags_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = in1;
                    b_d        = sub ? ~in2 : in2;
                    carry_d    = sub | c_in;
                    k_d        = '0;
                    sum_d      = '0;
                    pacc_d     = 1'b1;
                    gacc_d     = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end

            RUN: begin
                sum_d   = (sum_q & ~(CHUNK_MASK << shamt)) | (WIDTH'(ch_sum) << shamt);
                carry_d = ch_cout;
                pacc_d  = pacc_q & ch_pc;
                gacc_d  = ch_gc | (ch_pc & gacc_q);
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    out_d          = sum_d;
                    flags_d.c_out  = ch_cout;
                    flags_d.ovf    = ch_c_msb ^ ch_cout;
                    flags_d.zero   = (sum_d == '0);
                    flags_d.p_word = pacc_d;
                    flags_d.g_word = gacc_d;
                    out_valid_d    = 1'b1;
                    state_d        = DONE;
                end
            end

            DONE: begin
                // Result registers are left as-is; consumers qualify with out_valid.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values,
        // independent of statement order.
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            k_q         <= '0;
            sum_q       <= '0;
            pacc_q      <= 1'b0;
            gacc_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            k_q         <= k_d;
            sum_q       <= sum_d;
            pacc_q      <= pacc_d;
            gacc_q      <= gacc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            flags_q     <= flags_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign c_out     = flags_q.c_out;
    assign ovf       = flags_q.ovf;
    assign zero      = flags_q.zero;
    assign P$        = flags_q.p_word;
    assign G$        = flags_q.g_word;

endmodule

// File: tb/tb_cla_adder_seq.sv
// Self-checking bench for cla_adder_seq at WIDTH=16, CHUNK=4: arithmetic
// reference model, per-cycle output monitor and directed vectors.
module tb_cla_adder_seq;

    localparam int N = 4;

    typedef struct packed {
        logic [15:0] out;
        logic        c_out;
        logic        ovf;
        logic        zero;
        logic        p;
        logic        g;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        c_in;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        c_out;
    logic        ovf;
    logic        zero;
    logic        p_word;
    logic        g_word;

    int   checks      = 0;
    int   failures    = 0;
    int   cyc         = 0;
    int   accept_cyc  = 0;
    int   last_accept = 0;
    res_t exp_r       = '0;
    logic exp_valid   = 1'b0;

    cla_adder_seq #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero),
        .P$        (p_word),
        .G$        (g_word)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Plain wide arithmetic: the sum is the low 16 bits of a 17-bit add, signed
    // overflow from operand/result sign bits, P/G from the whole-word operands.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic s);
        res_t        r;
        logic [15:0] bp;
        logic        c0;
        logic [16:0] full;
        logic [16:0] nocarry;
        bp      = s ? ~b : b;
        c0      = s ? 1'b1 : ci;
        full    = {1'b0, a} + {1'b0, bp} + 17'(c0);
        nocarry = {1'b0, a} + {1'b0, bp};
        r.out   = full[15:0];
        r.c_out = full[16];
        r.ovf   = (a[15] == bp[15]) && (full[15] != a[15]);
        r.zero  = (full[15:0] == 16'h0000);
        r.p     = ((a ^ bp) == 16'hFFFF);
        r.g     = nocarry[16];
        return r;
    endfunction

    // Compare process: every cycle a result is presented it must match the model.
    initial begin : monitor
        int lat_checked;
        lat_checked = -1;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && exp_valid) begin
                check("mon_out",      32'(out),      32'(exp_r.out));
                check("mon_c_out",    32'(c_out),    32'(exp_r.c_out));
                check("mon_ovf",      32'(ovf),      32'(exp_r.ovf));
                check("mon_zero",     32'(zero),     32'(exp_r.zero));
                check("mon_p_word",   32'(p_word),   32'(exp_r.p));
                check("mon_g_word",   32'(g_word),   32'(exp_r.g));
                check("mon_in_ready", 32'(in_ready), 32'h0);
                if (accept_cyc != lat_checked) begin
                    check("latency", cyc - accept_cyc, N);
                    lat_checked = accept_cyc;
                end
            end
        end
    end

    task automatic start_op(input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic s);
        logic rdy;
        logic ok;
        ok       = 1'b0;
        in1      = a;
        in2      = b;
        c_in     = ci;
        sub      = s;
        in_valid = 1'b1;
        exp_r    = model(a, b, ci, s);
        exp_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        in_valid = 1'b0;
        check("accept_timeout", 32'(ok), 32'h1);
        last_accept = accept_cyc;
        accept_cyc  = cyc;
    endtask

    task automatic wait_valid();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("out_valid_timeout", 32'(seen), 32'h1);
    endtask

    task automatic check_handshake_done();
        @(posedge clk);
        #1;
        check("post_done_in_ready",  32'(in_ready),  32'h1);
        check("post_done_out_valid", 32'(out_valid), 32'h0);
    endtask

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        s;
        logic [15:0] want;
    } vec_t;

    vec_t vecs [8];
    res_t m;
    logic leaked;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0;
        c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;

        // Model pins: hand-computed values for the model itself.
        m = model(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("model_add_out", 32'(m.out), 32'h0000);
        check("model_add_g",   32'(m.g),   32'h1);
        check("model_add_p",   32'(m.p),   32'h0);
        m = model(16'h8000, 16'h0001, 1'b0, 1'b1);
        check("model_sub_out", 32'(m.out), 32'h7FFF);
        check("model_sub_ovf", 32'(m.ovf), 32'h1);
        m = model(16'h0003, 16'h0005, 1'b0, 1'b1);
        check("model_borrow",  32'(m.c_out), 32'h0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  32'h1);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out",       32'(out),       32'h0);
        check("rst_flags",     32'({c_out, ovf, zero, p_word, g_word}), 32'h0);
        rst = 1'b0;

        // 1: wrap to zero with carry.
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_valid();
        check("t1_out",  32'(out), 32'h0000);
        check("t1_flags", 32'({c_out, ovf, zero, p_word, g_word}), 32'b10101);
        check_handshake_done();

        // 2: signed overflow on subtract, then a borrow.
        start_op(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_valid();
        check("t2a_out",   32'(out), 32'h7FFF);
        check("t2a_flags", 32'({c_out, ovf, zero}), 32'b110);
        check_handshake_done();
        start_op(16'h0003, 16'h0005, 1'b0, 1'b1);
        wait_valid();
        check("t2b_out",   32'(out), 32'hFFFE);
        check("t2b_flags", 32'({c_out, ovf}), 32'b00);
        check_handshake_done();

        // 3: carry-in ripples through every chunk register.
        start_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        wait_valid();
        check("t3_out",  32'(out), 32'h0000);
        check("t3_flags", 32'({c_out, p_word, g_word}), 32'b110);
        check_handshake_done();

        // 4: backpressure with a stray in_valid pulse.
        out_ready = 1'b0;
        start_op(16'h1357, 16'h2468, 1'b0, 1'b0);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) begin
                in1 = 16'hAAAA; in2 = 16'h5555; in_valid = 1'b1;
            end
            if (i == 3) in_valid = 1'b0;
            check("t4_hold_in_ready",  32'(in_ready),  32'h0);
            check("t4_hold_out_valid", 32'(out_valid), 32'h1);
            check("t4_hold_out",       32'(out),       32'h37BF);
        end
        out_ready = 1'b1;
        check_handshake_done();
        @(posedge clk);
        #1;
        check("t4_not_captured", 32'(in_ready), 32'h1);

        // 5: reset while chunk 2 would be processed.
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        exp_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_in_ready",  32'(in_ready),  32'h1);
        check("t5_out_valid", 32'(out_valid), 32'h0);
        check("t5_out",       32'(out),       32'h0);
        leaked = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) leaked = 1'b1;
        end
        check("t5_aborted_hidden", 32'(leaked), 32'h0);
        @(posedge clk);
        #1;
        start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_valid();
        check("t5_after_out", 32'(out), 32'h0002);
        @(posedge clk);
        #1;

        // 6: back-to-back with out_ready high; spacing must be N+2.
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555};
        vecs[1] = '{16'h5555, 16'h1234, 1'b0, 1'b1, 16'h4321};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000};
        vecs[3] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000};
        vecs[5] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000};
        vecs[6] = '{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF};
        vecs[7] = '{16'hFFFF, 16'h7FFF, 1'b0, 1'b1, 16'h8000};
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s);
            if (i > 0) check("t6_spacing", accept_cyc - last_accept, N + 2);
            wait_valid();
            check("t6_out", 32'(out), 32'(vecs[i].want));
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
